// File: rtl/ysyx_24090003_csr_pkg.sv
// Shared CSR addresses, op encoding, mstatus layout and reset constants
// for the GPR/CSR architectural state block.
package ysyx_24090003_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // MPP is hardwired to M-mode, so these bits are always set.
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

    // True for a GPR index that names real, writable storage.
    function automatic logic gpr_valid(input logic [4:0] a, input int unsigned n);
        return (a != 5'd0) && ({27'd0, a} < n);
    endfunction

endpackage

// File: rtl/ysyx_24090003_gpr_csr_file_if.sv
// Decode/writeback/trap-side bus of the GPR/CSR state block.
interface ysyx_24090003_gpr_csr_file_if #(parameter int NR_RPORTS = 2);
    logic [5*NR_RPORTS-1:0]  i_rs_addr;
    logic [32*NR_RPORTS-1:0] o_rs_data;
    logic                    i_rd_wen;
    logic [4:0]              i_rd_addr;
    logic [31:0]             i_rd_wdata;
    logic [11:0]             i_csr_addr;
    logic                    i_csr_we;
    logic [1:0]              i_csr_op;
    logic                    i_csr_wsrc0;
    logic [31:0]             i_csr_wdata;
    logic [31:0]             o_csr_rdata;
    logic                    o_csr_illegal;
    logic                    i_trap;
    logic [31:0]             i_trap_cause;
    logic [31:0]             i_trap_pc;
    logic                    i_mret;
    logic                    i_retire;
    logic [31:0]             o_mtvec;
    logic [31:0]             o_mepc;

    modport slave (
        input  i_rs_addr, i_rd_wen, i_rd_addr, i_rd_wdata,
        input  i_csr_addr, i_csr_we, i_csr_op, i_csr_wsrc0, i_csr_wdata,
        input  i_trap, i_trap_cause, i_trap_pc, i_mret, i_retire,
        output o_rs_data, o_csr_rdata, o_csr_illegal, o_mtvec, o_mepc
    );

    modport master (
        output i_rs_addr, i_rd_wen, i_rd_addr, i_rd_wdata,
        output i_csr_addr, i_csr_we, i_csr_op, i_csr_wsrc0, i_csr_wdata,
        output i_trap, i_trap_cause, i_trap_pc, i_mret, i_retire,
        input  o_rs_data, o_csr_rdata, o_csr_illegal, o_mtvec, o_mepc
    );
endinterface

// File: rtl/ysyx_24090003_csr_counter64.sv
// 64-bit CSR counter: a write to either half replaces it and skips that
// cycle's increment; the untouched half holds.
module ysyx_24090003_csr_counter64 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] q_o
);
    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (we_lo_i)      cnt_d[31:0]  = wdata_i;
        else if (we_hi_i) cnt_d[63:32] = wdata_i;
        else if (inc_i)   cnt_d        = cnt_q + 64'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign q_o = cnt_q;
endmodule

// File: rtl/ysyx_24090003_gpr_csr_file.sv
// N-read/1-write GPR file plus M-mode CSRs with trap entry/mret stacking.
// Define YSYX_24090003_RF_COUNTERS_EN to implement mcycle/minstret.
module ysyx_24090003_gpr_csr_file
    import ysyx_24090003_csr_pkg::*;
#(
    parameter int          NR_GPR    = 32,
    parameter int          NR_RPORTS = 2,
    parameter int          BYPASS    = 1,
    parameter logic [31:0] MVENDORID = 32'h79737978,
    parameter logic [31:0] MARCHID   = 32'd24090003
) (
    input logic i_clk,
    input logic i_rst_n,
    ysyx_24090003_gpr_csr_file_if.slave bus
);
    localparam int AW = $clog2(NR_GPR);

    logic [31:0] gpr_q [NR_GPR];
    logic        gpr_we;
    logic [NR_RPORTS-1:0][31:0] rs_data;

    assign gpr_we = bus.i_rd_wen && gpr_valid(bus.i_rd_addr, NR_GPR);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NR_GPR; i++) gpr_q[i] <= '0;
        end else if (gpr_we) begin
            gpr_q[bus.i_rd_addr[AW-1:0]] <= bus.i_rd_wdata;
        end
    end

    for (genvar p = 0; p < NR_RPORTS; p++) begin : g_rport
        logic [4:0] ra;
        assign ra = bus.i_rs_addr[5*p +: 5];
        assign rs_data[p] = !gpr_valid(ra, NR_GPR)                             ? 32'd0 :
                            (BYPASS != 0 && gpr_we && bus.i_rd_addr == ra) ? bus.i_rd_wdata :
                            gpr_q[ra[AW-1:0]];
    end
    assign bus.o_rs_data = rs_data;

    csr_op_e     op;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] mstatus_rd, old_v, new_v;
    logic [63:0] mcycle, minstret;
    logic        unimpl, ro, wr_attempt, illegal, csr_wr;

    assign op         = csr_op_e'(bus.i_csr_op);
    assign mstatus_rd = MSTATUS_RST | (32'(mie_q) << MSTATUS_MIE) | (32'(mpie_q) << MSTATUS_MPIE);

    always_comb begin
        old_v  = '0;
        unimpl = 1'b0;
        ro     = 1'b0;
        case (bus.i_csr_addr)
            CSR_MSTATUS:   old_v = mstatus_rd;
            CSR_MTVEC:     old_v = mtvec_q;
            CSR_MEPC:      old_v = mepc_q;
            CSR_MCAUSE:    old_v = mcause_q;
            CSR_MCYCLE:    old_v = mcycle[31:0];
            CSR_MCYCLEH:   old_v = mcycle[63:32];
            CSR_MINSTRET:  old_v = minstret[31:0];
            CSR_MINSTRETH: old_v = minstret[63:32];
            CSR_MVENDORID: begin old_v = MVENDORID; ro = 1'b1; end
            CSR_MARCHID:   begin old_v = MARCHID;   ro = 1'b1; end
            default:       unimpl = 1'b1;
        endcase
    end

    // RS/RC with a zero source are pure reads, so they never trip read-only checks.
    assign wr_attempt = bus.i_csr_we && (op == CSR_RW || (op != CSR_NONE && !bus.i_csr_wsrc0));
    assign illegal    = unimpl || (ro && wr_attempt);
    assign csr_wr     = wr_attempt && !illegal && !bus.i_trap && !bus.i_mret;

    always_comb begin
        unique case (op)
            CSR_RW:  new_v = bus.i_csr_wdata;
            CSR_RS:  new_v = old_v | bus.i_csr_wdata;
            CSR_RC:  new_v = old_v & ~bus.i_csr_wdata;
            default: new_v = old_v;
        endcase
    end

    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (bus.i_trap) begin
            mepc_d   = {bus.i_trap_pc[31:2], 2'b00};
            mcause_d = bus.i_trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (bus.i_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_wr) begin
            case (bus.i_csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = new_v[MSTATUS_MIE];
                    mpie_d = new_v[MSTATUS_MPIE];
                end
                CSR_MTVEC:  mtvec_d  = {new_v[31:2], 2'b00};
                CSR_MEPC:   mepc_d   = {new_v[31:2], 2'b00};
                CSR_MCAUSE: mcause_d = new_v;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mie_q    <= MSTATUS_RST[MSTATUS_MIE];
            mpie_q   <= MSTATUS_RST[MSTATUS_MPIE];
            mtvec_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

`ifdef YSYX_24090003_RF_COUNTERS_EN
    ysyx_24090003_csr_counter64 u_mcycle (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .inc_i   (1'b1),
        .we_lo_i (csr_wr && bus.i_csr_addr == CSR_MCYCLE),
        .we_hi_i (csr_wr && bus.i_csr_addr == CSR_MCYCLEH),
        .wdata_i (new_v),
        .q_o     (mcycle)
    );
    ysyx_24090003_csr_counter64 u_minstret (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .inc_i   (bus.i_retire),
        .we_lo_i (csr_wr && bus.i_csr_addr == CSR_MINSTRET),
        .we_hi_i (csr_wr && bus.i_csr_addr == CSR_MINSTRETH),
        .wdata_i (new_v),
        .q_o     (minstret)
    );
`else
    assign mcycle   = '0;
    assign minstret = '0;
    logic unused_retire;
    assign unused_retire = bus.i_retire;
`endif

    logic unused_pc_lo;
    assign unused_pc_lo = ^bus.i_trap_pc[1:0];

    assign bus.o_csr_rdata   = old_v;
    assign bus.o_csr_illegal = illegal;
    assign bus.o_mtvec       = mtvec_q;
    assign bus.o_mepc        = mepc_q;
endmodule

// File: tb/tb_ysyx_24090003_gpr_csr_file.sv
// Randomised bench for the GPR/CSR block against an architectural-level model,
// with directed literal checks; a second RV32E (16-GPR) instance shares stimulus.
module tb_ysyx_24090003_gpr_csr_file;
    import ysyx_24090003_csr_pkg::*;

    localparam int          NRP = 2;
    localparam logic [31:0] VID = 32'h79737978;
    localparam logic [31:0] AID = 32'd24090003;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_24090003_gpr_csr_file_if #(.NR_RPORTS(NRP)) bus ();
    ysyx_24090003_gpr_csr_file_if #(.NR_RPORTS(NRP)) bus_e ();

    assign bus_e.i_rs_addr    = bus.i_rs_addr;
    assign bus_e.i_rd_wen     = bus.i_rd_wen;
    assign bus_e.i_rd_addr    = bus.i_rd_addr;
    assign bus_e.i_rd_wdata   = bus.i_rd_wdata;
    assign bus_e.i_csr_addr   = bus.i_csr_addr;
    assign bus_e.i_csr_we     = bus.i_csr_we;
    assign bus_e.i_csr_op     = bus.i_csr_op;
    assign bus_e.i_csr_wsrc0  = bus.i_csr_wsrc0;
    assign bus_e.i_csr_wdata  = bus.i_csr_wdata;
    assign bus_e.i_trap       = bus.i_trap;
    assign bus_e.i_trap_cause = bus.i_trap_cause;
    assign bus_e.i_trap_pc    = bus.i_trap_pc;
    assign bus_e.i_mret       = bus.i_mret;
    assign bus_e.i_retire     = bus.i_retire;

    ysyx_24090003_gpr_csr_file #(.NR_GPR(32), .NR_RPORTS(NRP), .BYPASS(1),
        .MVENDORID(VID), .MARCHID(AID)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    ysyx_24090003_gpr_csr_file #(.NR_GPR(16), .NR_RPORTS(NRP), .BYPASS(1),
        .MVENDORID(VID), .MARCHID(AID)) dut_e (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_e));

    int checks = 0;
    int errors = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_ms, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;
    logic [11:0] addr_tab [14];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] m_warl(logic [31:0] v);
        return (v & 32'h88) | 32'h1800;
    endfunction

    function automatic logic [31:0] m_rs(logic [4:0] a, int nr);
        if (a == 5'd0 || int'(a) >= nr) return 32'd0;
        if (bus.i_rd_wen && bus.i_rd_addr == a) return bus.i_rd_wdata;
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] m_csr(logic [11:0] a);
        case (a)
            12'h300: return m_ms;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef YSYX_24090003_RF_COUNTERS_EN
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
`endif
            12'hF11: return VID;
            12'hF12: return AID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_ill();
        logic [11:0] a;
        logic wr;
        a  = bus.i_csr_addr;
        wr = bus.i_csr_we && (bus.i_csr_op == 2'b01 || (bus.i_csr_op != 2'b00 && !bus.i_csr_wsrc0));
        if (!(a inside {12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80,
                        12'hB02, 12'hB82, 12'hF11, 12'hF12})) return 1'b1;
        return (a inside {12'hF11, 12'hF12}) && wr;
    endfunction

    task automatic check_all();
        for (int p = 0; p < NRP; p++) begin
            chk($sformatf("rs%0d", p), bus.o_rs_data[32*p +: 32], m_rs(bus.i_rs_addr[5*p +: 5], 32));
            chk($sformatf("rs%0d_e", p), bus_e.o_rs_data[32*p +: 32], m_rs(bus.i_rs_addr[5*p +: 5], 16));
        end
        chk("csr_rdata", bus.o_csr_rdata, m_csr(bus.i_csr_addr));
        chk("csr_illegal", {31'd0, bus.o_csr_illegal}, {31'd0, m_ill()});
        chk("mtvec", bus.o_mtvec, m_mtvec);
        chk("mepc", bus.o_mepc, m_mepc);
    endtask

    task automatic model_update();
        logic [31:0] old, nv;
        logic [63:0] cyc0, ins0;
        logic wr;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_ms = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        if (bus.i_rd_wen && bus.i_rd_addr != 5'd0) m_gpr[bus.i_rd_addr] = bus.i_rd_wdata;
        old = m_csr(bus.i_csr_addr);
        case (bus.i_csr_op)
            2'b01:   nv = bus.i_csr_wdata;
            2'b10:   nv = old | bus.i_csr_wdata;
            2'b11:   nv = old & ~bus.i_csr_wdata;
            default: nv = old;
        endcase
        wr = bus.i_csr_we && bus.i_csr_op != 2'b00 && !m_ill()
             && !(bus.i_csr_op[1] && bus.i_csr_wsrc0);
        cyc0 = m_cyc; ins0 = m_ins;
        m_cyc = m_cyc + 64'd1;
        if (bus.i_retire) m_ins = m_ins + 64'd1;
        if (bus.i_trap) begin
            m_mepc   = bus.i_trap_pc & ~32'd3;
            m_mcause = bus.i_trap_cause;
            m_ms     = m_warl((m_ms & ~32'h88) | (m_ms[3] ? 32'h80 : 32'h0));
        end else if (bus.i_mret) begin
            m_ms = m_warl((m_ms & ~32'h08) | (m_ms[7] ? 32'h08 : 32'h0) | 32'h80);
        end else if (wr) begin
            case (bus.i_csr_addr)
                12'h300: m_ms     = m_warl(nv);
                12'h305: m_mtvec  = nv & ~32'd3;
                12'h341: m_mepc   = nv & ~32'd3;
                12'h342: m_mcause = nv;
                12'hB00: m_cyc    = {cyc0[63:32], nv};
                12'hB80: m_cyc    = {nv, cyc0[31:0]};
                12'hB02: m_ins    = {ins0[63:32], nv};
                12'hB82: m_ins    = {nv, ins0[31:0]};
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(logic [11:0] ca);
        bus.i_rs_addr = '0; bus.i_rd_wen = 0; bus.i_rd_addr = 0; bus.i_rd_wdata = 0;
        bus.i_csr_addr = ca; bus.i_csr_we = 0; bus.i_csr_op = 2'b00; bus.i_csr_wsrc0 = 0;
        bus.i_csr_wdata = 0; bus.i_trap = 0; bus.i_trap_cause = 0; bus.i_trap_pc = 0;
        bus.i_mret = 0; bus.i_retire = 0;
    endtask

    task automatic csr_cmd(logic [11:0] ca, logic [1:0] op, logic [31:0] wd, logic z);
        idle(ca);
        bus.i_csr_we = 1; bus.i_csr_op = op; bus.i_csr_wdata = wd; bus.i_csr_wsrc0 = z;
    endtask

    task automatic do_reset();
        idle(CSR_MSTATUS);
        rst_n = 0;
        @(posedge clk); model_update(); @(negedge clk);
        tick();
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] r, u;
        addr_tab = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
                     12'hB82, 12'hF11, 12'hF12, 12'h301, 12'h000, 12'hB01, 12'h7FF};
        do_reset();

        idle(CSR_MSTATUS); bus.i_rs_addr = {5'd31, 5'd1};
        #1 chk("rst_rs0", bus.o_rs_data[31:0], 32'd0);
        chk("rst_rs1", bus.o_rs_data[63:32], 32'd0);
        chk("rst_mstatus", bus.o_csr_rdata, 32'h1800);
        chk("rst_mtvec", bus.o_mtvec, 32'd0);
        tick();

        idle(CSR_MSTATUS); bus.i_rd_wen = 1; bus.i_rd_addr = 5; bus.i_rd_wdata = 32'hDEADBEEF;
        bus.i_rs_addr = {5'd0, 5'd5};
        #1 chk("bypass_x5", bus.o_rs_data[31:0], 32'hDEADBEEF);
        tick();
        idle(CSR_MSTATUS); bus.i_rd_wen = 1; bus.i_rd_addr = 20; bus.i_rd_wdata = 32'h12345678;
        bus.i_rs_addr = {5'd5, 5'd20};
        #1 chk("rve_x20_byp", bus_e.o_rs_data[31:0], 32'd0);
        chk("x5_stored", bus.o_rs_data[63:32], 32'hDEADBEEF);
        chk("rve_x5_stored", bus_e.o_rs_data[63:32], 32'hDEADBEEF);
        tick();
        idle(CSR_MSTATUS); bus.i_rs_addr = {5'd0, 5'd20};
        #1 chk("rve_x20", bus_e.o_rs_data[31:0], 32'd0);
        chk("x20", bus.o_rs_data[31:0], 32'h12345678);
        tick();

        csr_cmd(CSR_MTVEC, CSR_RW, 32'h80000007, 0); tick();
        idle(CSR_MSTATUS); #1 chk("mtvec_warl", bus.o_mtvec, 32'h80000004);
        csr_cmd(CSR_MSTATUS, CSR_RS, 32'h8, 0); tick();
        idle(CSR_MSTATUS); #1 chk("mstatus_rs", bus.o_csr_rdata, 32'h1808);
        csr_cmd(CSR_MSTATUS, CSR_RC, 32'h8, 1); tick();
        idle(CSR_MSTATUS); #1 chk("mstatus_rc_x0", bus.o_csr_rdata, 32'h1808);

        idle(CSR_MSTATUS); bus.i_trap = 1; bus.i_trap_cause = MCAUSE_ECALL_M;
        bus.i_trap_pc = 32'h80000100; tick();
        idle(CSR_MSTATUS);
        #1 chk("trap_mstatus", bus.o_csr_rdata, 32'h1880);
        chk("trap_mepc", bus.o_mepc, 32'h80000100);
        bus.i_csr_addr = CSR_MCAUSE;
        #1 chk("trap_mcause", bus.o_csr_rdata, 32'd11);
        tick();
        idle(CSR_MSTATUS); bus.i_mret = 1; tick();
        idle(CSR_MSTATUS); #1 chk("mret_mstatus", bus.o_csr_rdata, 32'h1888);

        csr_cmd(CSR_MTVEC, CSR_RW, 32'h1234, 0);
        bus.i_trap = 1; bus.i_trap_cause = 32'd2; bus.i_trap_pc = 32'h80000200; bus.i_mret = 1;
        tick();
        idle(CSR_MSTATUS);
        #1 chk("prio_mstatus", bus.o_csr_rdata, 32'h1880);
        chk("prio_mtvec", bus.o_mtvec, 32'h80000004);
        chk("prio_mepc", bus.o_mepc, 32'h80000200);
        csr_cmd(CSR_MVENDORID, CSR_RW, 32'h0, 0);
        #1 chk("ro_illegal", {31'd0, bus.o_csr_illegal}, 32'd1);
        tick();
        idle(CSR_MVENDORID); #1 chk("ro_value", bus.o_csr_rdata, VID);

        do_reset();
`ifdef YSYX_24090003_RF_COUNTERS_EN
        csr_cmd(CSR_MCYCLE, CSR_RW, 32'hFFFFFFFF, 0); tick();
        idle(CSR_MCYCLE); #1 chk("mcycle_wr", bus.o_csr_rdata, 32'hFFFFFFFF);
        tick();
        idle(CSR_MCYCLE); #1 chk("mcycle_wrap_lo", bus.o_csr_rdata, 32'd0);
        bus.i_csr_addr = CSR_MCYCLEH; #1 chk("mcycle_carry_hi", bus.o_csr_rdata, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle(CSR_MINSTRET); bus.i_retire = (i != 1 && i != 4); tick();
        end
        idle(CSR_MINSTRET); #1 chk("minstret_cnt", bus.o_csr_rdata, 32'd3);
`else
        idle(CSR_MCYCLE); tick();
        csr_cmd(CSR_MCYCLE, CSR_RW, 32'h55, 0);
        #1 chk("nocnt_legal", {31'd0, bus.o_csr_illegal}, 32'd0);
        tick();
        idle(CSR_MCYCLE); #1 chk("nocnt_zero", bus.o_csr_rdata, 32'd0);
`endif
        tick();

        for (int n = 0; n < 3000; n++) begin
            r = $urandom; u = $urandom;
            idle(addr_tab[u[3:0] % 14]);
            bus.i_rs_addr   = r[9:0];
            bus.i_rd_wen    = r[10];
            bus.i_rd_addr   = r[15:11];
            bus.i_rd_wdata  = $urandom;
            bus.i_csr_we    = (r[17:16] != 2'b00);
            bus.i_csr_op    = r[19:18];
            bus.i_csr_wsrc0 = (r[22:20] == 3'd0);
            bus.i_csr_wdata = $urandom;
            bus.i_trap      = (r[26:23] == 4'd0);
            bus.i_trap_cause = $urandom;
            bus.i_trap_pc   = $urandom & ~32'd3;
            bus.i_mret      = (r[30:27] == 4'd1);
            bus.i_retire    = r[31];
            rst_n           = (u[15:8] != 8'd0);
            tick();
        end
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
